// File: rtl/blowfish128_pkg.sv
// Shared types and sizes for the blowfish128 stream adapter.
package blowfish128_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned BLOCK_W         = 128;
  localparam int unsigned KEY_W           = 448;
  localparam int unsigned WORDS_PER_BLOCK = 4;

  typedef enum logic [1:0] {
    StFill,
    StRun,
    StDrain
  } state_e;

endpackage

// File: rtl/blowfish128_word_shifter.sv
// 128-bit block register with parallel load and 32-bit MSB-first shift-in.
module blowfish128_word_shifter
  import blowfish128_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [BLOCK_W-1:0] load_data,
  input  logic               shift,
  input  logic [WORD_W-1:0]  shift_in,
  output logic [BLOCK_W-1:0] data
);

  logic [BLOCK_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_data;
    end else if (shift) begin
      data_q <= {data_q[BLOCK_W-WORD_W-1:0], shift_in};
    end
  end

  assign data = data_q;

endmodule

// File: rtl/blowfish128_stream_adapter.sv
// Packs a 32-bit word stream into 128-bit blocks for blowfish128_top, runs one
// core operation per block and streams the 128-bit result back out as words.
module blowfish128_stream_adapter
  import blowfish128_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               cfg_encrypt,
  input  logic [3:0]         cfg_key_length,
  input  logic [KEY_W-1:0]   cfg_key,
  output logic [WORD_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               core_enable,
  output logic               core_encrypt,
  output logic [BLOCK_W-1:0] core_plaintext,
  output logic [KEY_W-1:0]   core_key,
  output logic [3:0]         core_key_length,
  input  logic [BLOCK_W-1:0] core_ciphertext,
  input  logic               core_cipher_ready,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   blocks_done
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  state_e             state;
  logic [1:0]         idx;
  logic [GAP_W-1:0]   gap_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [BLOCK_W-1:0] out_block;
  logic               s_hs;
  logic               m_hs;
  logic               capture;

  // Word3 is held off until the core has seen its minimum Enable-low gap.
  assign s_ready = !rst && (state == StFill) && ((gap_cnt == '0) || (idx != 2'd3));
  assign m_valid = (state == StDrain);
  assign m_last  = m_valid && (idx == 2'd3);
  assign s_hs    = s_valid && s_ready;
  assign m_hs    = m_valid && m_ready;
  assign capture = (state == StRun) && core_cipher_ready;

  blowfish128_word_shifter u_packer (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_data ('0),
    .shift     (s_hs),
    .shift_in  (s_data),
    .data      (core_plaintext)
  );

  blowfish128_word_shifter u_unpacker (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .load_data (core_ciphertext),
    .shift     (1'b0),
    .shift_in  ('0),
    .data      (out_block)
  );

  always_comb begin
    m_data = out_block[3*WORD_W +: WORD_W];
    unique case (idx)
      2'd0: m_data = out_block[3*WORD_W +: WORD_W];
      2'd1: m_data = out_block[2*WORD_W +: WORD_W];
      2'd2: m_data = out_block[1*WORD_W +: WORD_W];
      2'd3: m_data = out_block[0 +: WORD_W];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= StFill;
      idx             <= 2'd0;
      gap_cnt         <= GAP_W'(GAP_CYCLES);
      to_cnt          <= '0;
      core_enable     <= 1'b0;
      core_encrypt    <= 1'b0;
      core_key        <= '0;
      core_key_length <= 4'd0;
      timeout_err     <= 1'b0;
      blocks_done     <= '0;
    end else begin
      if (!core_enable && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
      unique case (state)
        StFill: begin
          if (s_hs) begin
            idx <= idx + 2'd1;
            if (idx == 2'd0) begin
              core_encrypt    <= cfg_encrypt;
              core_key_length <= cfg_key_length;
              core_key        <= cfg_key;
            end
            if (idx == 2'd3) begin
              state       <= StRun;
              core_enable <= 1'b1;
              to_cnt      <= '0;
            end
          end
        end
        StRun: begin
          // Ready beats timeout when both land on the same cycle.
          if (core_cipher_ready) begin
            core_enable <= 1'b0;
            gap_cnt     <= GAP_W'(GAP_CYCLES);
            state       <= StDrain;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            core_enable <= 1'b0;
            gap_cnt     <= GAP_W'(GAP_CYCLES);
            state       <= StFill;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        StDrain: begin
          if (m_hs) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              blocks_done <= blocks_done + CNT_W'(1);
              state       <= StFill;
            end
          end
        end
        default: state <= StFill;
      endcase
    end
  end

endmodule

// File: tb/tb_blowfish128_stream_adapter.sv
// Directed bench for blowfish128_stream_adapter against a reversible stub core
// (encrypt = rotl32 then XOR key-mix, decrypt = inverse) with hand-computed vectors.
module tb_blowfish128_stream_adapter;
  localparam int unsigned GAP = 2;
  localparam int unsigned TMO = 16;

  localparam logic [447:0] KEY = {320'h0, 64'h11112222_33334444, 64'haabb0918_2736ccdd};
  localparam logic [127:0] PT  = 128'h123456ab_cd132536_123456ab_cd132536;
  localparam logic [127:0] CT  = 128'h67a82c2e_35029a76_dc020714_210712ef;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic         cfg_encrypt = 1'b0;
  logic [3:0]   cfg_key_length = '0;
  logic [447:0] cfg_key = '0;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         m_last;
  logic         core_enable;
  logic         core_encrypt;
  logic [127:0] core_plaintext;
  logic [447:0] core_key;
  logic [3:0]   core_key_length;
  logic [127:0] core_ciphertext;
  logic         core_cipher_ready;
  logic         timeout_err;
  logic [15:0]  blocks_done;

  always #5 clk = ~clk;

  blowfish128_stream_adapter #(
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TMO),
    .CNT_W      (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .cfg_encrypt       (cfg_encrypt),
    .cfg_key_length    (cfg_key_length),
    .cfg_key           (cfg_key),
    .m_data            (m_data),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_last            (m_last),
    .core_enable       (core_enable),
    .core_encrypt      (core_encrypt),
    .core_plaintext    (core_plaintext),
    .core_key          (core_key),
    .core_key_length   (core_key_length),
    .core_ciphertext   (core_ciphertext),
    .core_cipher_ready (core_cipher_ready),
    .timeout_err       (timeout_err),
    .blocks_done       (blocks_done)
  );

  // Stub core: ready four cycles after Enable rises unless hung.
  function automatic logic [127:0] stub_f(input logic [127:0] d, input logic enc,
                                          input logic [447:0] k);
    logic [127:0] k2;
    logic [127:0] t;
    k2 = {k[63:0], k[127:64]};
    if (enc) begin
      stub_f = {d[95:0], d[127:96]} ^ k2;
    end else begin
      t = d ^ k2;
      stub_f = {t[31:0], t[127:32]};
    end
  endfunction

  logic stub_hang = 1'b0;
  int   stub_cnt  = 0;
  logic stub_ready = 1'b0;

  always @(posedge clk) begin
    if (rst || !core_enable) begin
      stub_cnt   <= 0;
      stub_ready <= 1'b0;
    end else if (stub_cnt == 3) begin
      stub_ready <= !stub_hang;
    end else begin
      stub_cnt <= stub_cnt + 1;
    end
  end

  assign core_cipher_ready = stub_ready;
  assign core_ciphertext   = stub_f(core_plaintext, core_encrypt, core_key);

  // Output collector and Enable-low gap monitor.
  logic [31:0] out_data [0:63];
  logic        out_last [0:63];
  int          out_n = 0;
  int          mvalid_cycles = 0;
  int          low_run = 0;
  int          min_gap = 1000;
  logic        gap_clr = 1'b0;

  always @(posedge clk) begin
    if (!rst && m_valid) begin
      mvalid_cycles <= mvalid_cycles + 1;
      if (m_ready && out_n < 64) begin
        out_data[out_n] <= m_data;
        out_last[out_n] <= m_last;
        out_n <= out_n + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (gap_clr) begin
      min_gap <= 1000;
      low_run <= 0;
    end else if (core_enable) begin
      if (low_run > 0 && low_run < min_gap) min_gap <= low_run;
      low_run <= 0;
    end else begin
      low_run <= low_run + 1;
    end
  end

  int total  = 0;
  int passed = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [447:0] obs, input logic [447:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    int n;
    s_data  = w;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("s_ready_wait", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Config is scrambled after word0 so only the latched copy can be right.
  task automatic send_block(input logic [127:0] blk, input logic enc, input logic [447:0] key,
                            input logic [3:0] len);
    cfg_encrypt    = enc;
    cfg_key        = key;
    cfg_key_length = len;
    for (int i = 0; i < 4; i++) begin
      send_word(blk[127-32*i -: 32]);
      if (i == 0) begin
        cfg_encrypt    = ~enc;
        cfg_key        = ~key;
        cfg_key_length = ~len;
      end
    end
  endtask

  task automatic wait_out(input int target);
    int n;
    n = 0;
    while (out_n < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("out_count", out_n, target);
  endtask

  task automatic check_block(input string tag, input int base, input logic [127:0] exp);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_w%0d", tag, i), out_data[base+i], exp[127-32*i -: 32]);
      chk($sformatf("%s_last%0d", tag, i), out_last[base+i], (i == 3));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    int mv0;

    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_core_enable", core_enable, 0);
    chk("rst_m_valid", m_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", s_ready, 1);
    chk("idle_m_data", m_data, 0);
    chk("idle_m_last", m_last, 0);
    chk("idle_plaintext", core_plaintext, 0);
    chk("idle_key", core_key, 0);
    chk("idle_key_length", core_key_length, 0);
    chk("idle_encrypt", core_encrypt, 0);
    chk("idle_timeout_err", timeout_err, 0);
    chk("idle_blocks_done", blocks_done, 0);

    // Single encrypt block with latency checks.
    m_ready = 1'b1;
    base = out_n;
    send_block(PT, 1'b1, KEY, 4'd2);
    chk("enable_latency", core_enable, 1);
    chk("core_plaintext", core_plaintext, PT);
    chk("core_key_latched", core_key, KEY);
    chk("core_encrypt_latched", core_encrypt, 1);
    chk("core_key_length_latched", core_key_length, 2);
    chk("s_ready_in_run", s_ready, 0);
    n = 0;
    while (!core_cipher_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_seen", core_cipher_ready, 1);
    @(negedge clk);
    chk("m_valid_latency", m_valid, 1);
    chk("enable_fall", core_enable, 0);
    chk("first_word", m_data, CT[127:96]);
    wait_out(base + 4);
    check_block("enc", base, CT);
    chk("blocks_done_1", blocks_done, 1);

    // Round trip through decrypt.
    base = out_n;
    send_block(CT, 1'b0, KEY, 4'd2);
    wait_out(base + 4);
    check_block("dec", base, PT);
    chk("blocks_done_2", blocks_done, 2);

    // Downstream stall after two words.
    m_ready = 1'b0;
    base = out_n;
    send_block(PT, 1'b1, KEY, 4'd2);
    n = 0;
    while (!m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_m_valid", m_valid, 1);
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold_data%0d", k), m_data, CT[63:32]);
      chk($sformatf("bp_hold_last%0d", k), m_last, 0);
      chk($sformatf("bp_s_ready%0d", k), s_ready, 0);
      @(negedge clk);
    end
    m_ready = 1'b1;
    wait_out(base + 4);
    repeat (3) @(negedge clk);
    chk("bp_no_dup", out_n, base + 4);
    check_block("bp", base, CT);
    chk("blocks_done_3", blocks_done, 3);

    // Core never answers.
    stub_hang = 1'b1;
    base = out_n;
    mv0 = mvalid_cycles;
    send_block(PT, 1'b1, KEY, 4'd2);
    n = 0;
    while (core_enable && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("to_enable_cycles", n, TMO);
    chk("to_err_set", timeout_err, 1);
    chk("to_s_ready", s_ready, 1);
    repeat (3) @(negedge clk);
    chk("to_no_m_valid", mvalid_cycles, mv0);
    stub_hang = 1'b0;
    send_block(CT, 1'b0, KEY, 4'd2);
    wait_out(base + 4);
    check_block("after_to", base, PT);
    chk("to_err_sticky", timeout_err, 1);
    chk("blocks_done_4", blocks_done, 4);

    // Reset while the core is running.
    stub_hang = 1'b1;
    send_block(PT, 1'b1, KEY, 4'd2);
    repeat (3) @(negedge clk);
    chk("rr_in_run", core_enable, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rr_enable", core_enable, 0);
    chk("rr_m_valid", m_valid, 0);
    chk("rr_s_ready", s_ready, 0);
    chk("rr_timeout_err", timeout_err, 0);
    chk("rr_blocks_done", blocks_done, 0);
    chk("rr_plaintext", core_plaintext, 0);
    chk("rr_key", core_key, 0);
    chk("rr_m_data", m_data, 0);
    rst = 1'b0;
    stub_hang = 1'b0;
    base = out_n;
    repeat (10) @(negedge clk);
    chk("rr_no_output", out_n, base);
    chk("rr_s_ready_after", s_ready, 1);

    // Three back-to-back blocks with free-flowing handshakes.
    gap_clr = 1'b1;
    @(negedge clk);
    gap_clr = 1'b0;
    m_ready = 1'b1;
    base = out_n;
    send_block(PT, 1'b1, KEY, 4'd2);
    send_block(CT, 1'b0, KEY, 4'd2);
    send_block(PT, 1'b1, KEY, 4'd2);
    wait_out(base + 12);
    check_block("b2b0", base, CT);
    check_block("b2b1", base + 4, PT);
    check_block("b2b2", base + 8, CT);
    chk("b2b_blocks_done", blocks_done, 3);
    chk("b2b_min_gap", (min_gap >= GAP) && (min_gap < 1000), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
